imem_boot_loader: RTL and testbench

Byte-stream loader that writes a program image into the instruction memory's write port. It holds the pipeline frozen until the image is complete. It sits between an external byte source (host/UART bridge) and the instruction memory, and drives the PC/pipeline hold. The pipeline's fetch stage is the reader of instruction memory; this block is the writer.

---
 rtl/imem_boot_loader.sv | 143 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Byte-stream program loader: assembles a big-endian word-count header and
// payload words, writes them to instruction memory, holds the core until done.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a load (accepted only in IDLE or DONE)
//   in_valid/in_data  byte stream from host; in_ready accepts a byte
//   imem_we/addr/wdata instruction memory write port (one word per strobe)
//   cpu_hold          freezes PC and pipeline while high
//   done, err         load complete / sticky header overflow error
//   words_loaded      words written in the current load
module imem_boot_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [31:0]           imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    // Largest legal word count is the full memory capacity.
    localparam logic [32:0] CAP = 33'd1 << ADDR_WIDTH;

    state_t              state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [31:0]         shift_q, shift_d;
    logic [ADDR_WIDTH:0] n_q, n_d;
    logic [ADDR_WIDTH:0] wl_q, wl_d;
    logic                err_q, err_d;

    logic                beat;
    logic [31:0]         next_word;
    logic [ADDR_WIDTH:0] wl_inc;

    // Header and payload share one shift register; big-endian means each
    // new byte enters at the bottom and earlier bytes move up.
    assign next_word = {shift_q[23:0], in_data};
    assign wl_inc    = wl_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        n_d        = n_q;
        wl_d       = wl_q;
        err_d      = err_q;
        beat       = in_valid && in_ready;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_HDR;
                    byte_cnt_d = 2'd0;
                    wl_d       = '0;
                    n_d        = '0;
                    err_d      = 1'b0;
                end
            end
            S_HDR: begin
                if (beat) begin
                    shift_d    = next_word;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (next_word == 32'd0) begin
                            state_d = S_DONE;
                        end else if ({1'b0, next_word} > CAP) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            n_d     = next_word[ADDR_WIDTH:0];
                            state_d = S_LOAD;
                        end
                    end
                end
            end
            S_LOAD: begin
                if (beat) begin
                    shift_d    = next_word;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                wl_d = wl_inc;
                if (wl_inc == n_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            shift_q    <= 32'd0;
            n_q        <= '0;
            wl_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            n_q        <= n_d;
            wl_q       <= wl_d;
            err_q      <= err_d;
        end
    end

    // All outputs decode registered state only.
    assign in_ready     = (state_q == S_HDR) || (state_q == S_LOAD);
    assign imem_we      = (state_q == S_WRITE);
    assign imem_addr    = BASE_ADDR + (32'(wl_q) << 2);
    assign imem_wdata   = shift_q;
    assign done         = (state_q == S_DONE);
    assign err          = err_q;
    assign cpu_hold     = !((state_q == S_DONE) && !err_q);
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_s    [2];
    logic        in_valid_s [2];
    logic [7:0]  in_data_s  [2];
    logic        in_ready_s [2];
    logic        imem_we_s  [2];
    logic [31:0] imem_addr_s[2];
    logic [31:0] imem_wdata_s[2];
    logic        cpu_hold_s [2];
    logic        done_s     [2];
    logic        err_s      [2];
    logic [8:0]  wl_s       [2];

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] exp0[$];
    logic [63:0] exp1[$];

    imem_boot_loader #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]),
        .in_valid(in_valid_s[0]), .in_data(in_data_s[0]),
        .in_ready(in_ready_s[0]), .imem_we(imem_we_s[0]),
        .imem_addr(imem_addr_s[0]), .imem_wdata(imem_wdata_s[0]),
        .cpu_hold(cpu_hold_s[0]), .done(done_s[0]), .err(err_s[0]),
        .words_loaded(wl_s[0])
    );

    imem_boot_loader #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0000_0400)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]),
        .in_valid(in_valid_s[1]), .in_data(in_data_s[1]),
        .in_ready(in_ready_s[1]), .imem_we(imem_we_s[1]),
        .imem_addr(imem_addr_s[1]), .imem_wdata(imem_wdata_s[1]),
        .cpu_hold(cpu_hold_s[1]), .done(done_s[1]), .err(err_s[1]),
        .words_loaded(wl_s[1])
    );

    // Scoreboard monitors: every write strobe pops one expected (addr,data).
    always @(negedge clk) begin
        logic [63:0] e;
        if (imem_we_s[0] === 1'b1) begin
            n_cmp++;
            if (exp0.size() == 0) begin
                n_bad++;
                $display("FAIL wr0_unexpected got addr=%h data=%h want none",
                         imem_addr_s[0], imem_wdata_s[0]);
            end else begin
                e = exp0.pop_front();
                if ({imem_addr_s[0], imem_wdata_s[0]} !== e) begin
                    n_bad++;
                    $display("FAIL wr0 got %h_%h want %h",
                             imem_addr_s[0], imem_wdata_s[0], e);
                end
            end
            n_cmp++;
            if (in_ready_s[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL rdy0_in_write got %b want 0", in_ready_s[0]);
            end
        end
    end

    always @(negedge clk) begin
        logic [63:0] e;
        if (imem_we_s[1] === 1'b1) begin
            n_cmp++;
            if (exp1.size() == 0) begin
                n_bad++;
                $display("FAIL wr1_unexpected got addr=%h data=%h want none",
                         imem_addr_s[1], imem_wdata_s[1]);
            end else begin
                e = exp1.pop_front();
                if ({imem_addr_s[1], imem_wdata_s[1]} !== e) begin
                    n_bad++;
                    $display("FAIL wr1 got %h_%h want %h",
                             imem_addr_s[1], imem_wdata_s[1], e);
                end
            end
            n_cmp++;
            if (in_ready_s[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL rdy1_in_write got %b want 0", in_ready_s[1]);
            end
        end
    end

    task automatic push_exp(input int i, input logic [31:0] a,
                            input logic [31:0] d);
        if (i == 0) exp0.push_back({a, d});
        else exp1.push_back({a, d});
    endtask

    task automatic pulse_start(input int i);
        start_s[i] = 1'b1;
        @(posedge clk); #1;
        start_s[i] = 1'b0;
    endtask

    // Present one byte and hold it until accepted; leaves in_valid low.
    task automatic send_byte(input int i, input logic [7:0] b);
        logic acc;
        int n;
        n = 0;
        acc = 1'b0;
        in_valid_s[i] = 1'b1;
        in_data_s[i]  = b;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready_s[i];
            @(posedge clk); #1;
            n++;
        end
        in_valid_s[i] = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_timeout got no accept want accept dut%0d", i);
        end
    endtask

    task automatic send_word(input int i, input logic [31:0] w,
                             input bit gaps);
        for (int k = 0; k < 4; k++) begin
            send_byte(i, w[31-8*k -: 8]);
            if (gaps && k < 3) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_done(input int i);
        int n;
        n = 0;
        while (done_s[i] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (done_s[i] !== 1'b1) begin
            n_bad++;
            $display("FAIL done_timeout got %b want 1 dut%0d", done_s[i], i);
        end
    endtask

    task automatic check_drained(input string nm);
        n_cmp++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            n_bad++;
            $display("FAIL %s_missing_writes got %0d/%0d pending want 0/0",
                     nm, exp0.size(), exp1.size());
        end
    endtask

    task automatic test_reset;
        pulse_start(0);
        send_word(0, 32'd2, 1'b0);
        send_byte(0, 8'hAA);
        send_byte(0, 8'hBB);
        in_valid_s[0] = 1'b1;
        in_data_s[0]  = 8'hCC;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_ready_s[0], imem_we_s[0], cpu_hold_s[0], done_s[0],
             err_s[0]} !== 5'b00100) begin
            n_bad++;
            $display("FAIL reset_flags got rdy/we/hold/done/err=%b%b%b%b%b want 00100",
                     in_ready_s[0], imem_we_s[0], cpu_hold_s[0], done_s[0],
                     err_s[0]);
        end
        n_cmp++;
        if (imem_addr_s[0] !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_addr got %h want 0", imem_addr_s[0]);
        end
        n_cmp++;
        if (imem_wdata_s[0] !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_wdata got %h want 0", imem_wdata_s[0]);
        end
        n_cmp++;
        if (wl_s[0] !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_wl got %0d want 0", wl_s[0]);
        end
        // Stream keeps offering bytes; nothing must be consumed or written.
        repeat (10) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready_s[0] !== 1'b0 || cpu_hold_s[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_idle got rdy=%b hold=%b want 0/1",
                         in_ready_s[0], cpu_hold_s[0]);
            end
        end
        @(posedge clk); #1;
        in_valid_s[0] = 1'b0;
        check_drained("reset");
    endtask

    task automatic run_two_words(input bit gaps, input string nm);
        push_exp(0, 32'h0, 32'h12345678);
        push_exp(0, 32'h4, 32'h9ABCDEF0);
        pulse_start(0);
        n_cmp++;
        @(negedge clk);
        if (in_ready_s[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_ready_after_start got %b want 1", nm,
                     in_ready_s[0]);
        end
        @(posedge clk); #1;
        send_word(0, 32'd2, gaps);
        send_word(0, 32'h12345678, gaps);
        send_word(0, 32'h9ABCDEF0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (imem_we_s[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_we_at_k1 got %b want 1", nm, imem_we_s[0]);
        end
        @(negedge clk);
        n_cmp++;
        if (done_s[0] !== 1'b1 || cpu_hold_s[0] !== 1'b0 ||
            err_s[0] !== 1'b0 || wl_s[0] !== 9'd2) begin
            n_bad++;
            $display("FAIL %s_final got done=%b hold=%b err=%b wl=%0d want 1/0/0/2",
                     nm, done_s[0], cpu_hold_s[0], err_s[0], wl_s[0]);
        end
        check_drained(nm);
    endtask

    task automatic test_basic;
        run_two_words(1'b0, "basic");
    endtask

    task automatic test_gaps;
        run_two_words(1'b1, "gaps");
    endtask

    task automatic test_empty;
        pulse_start(0);
        send_word(0, 32'd0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (done_s[0] !== 1'b1 || cpu_hold_s[0] !== 1'b0 ||
            err_s[0] !== 1'b0 || wl_s[0] !== 9'd0) begin
            n_bad++;
            $display("FAIL empty got done=%b hold=%b err=%b wl=%0d want 1/0/0/0",
                     done_s[0], cpu_hold_s[0], err_s[0], wl_s[0]);
        end
        repeat (3) @(posedge clk);
        #1;
        check_drained("empty");
    endtask

    task automatic test_overflow;
        pulse_start(0);
        send_word(0, 32'h0000_0101, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (done_s[0] !== 1'b1 || cpu_hold_s[0] !== 1'b1 ||
            err_s[0] !== 1'b1 || in_ready_s[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL overflow got done=%b hold=%b err=%b rdy=%b want 1/1/1/0",
                     done_s[0], cpu_hold_s[0], err_s[0], in_ready_s[0]);
        end
        repeat (3) @(posedge clk);
        #1;
        check_drained("overflow");
    endtask

    task automatic test_reload;
        pulse_start(0);
        @(negedge clk);
        n_cmp++;
        if (err_s[0] !== 1'b0 || done_s[0] !== 1'b0 ||
            in_ready_s[0] !== 1'b1 || cpu_hold_s[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL reload_clear got err=%b done=%b rdy=%b hold=%b want 0/0/1/1",
                     err_s[0], done_s[0], in_ready_s[0], cpu_hold_s[0]);
        end
        @(posedge clk); #1;
        push_exp(0, 32'h0, 32'hDEADBEEF);
        send_word(0, 32'd1, 1'b0);
        send_byte(0, 8'hDE);
        send_byte(0, 8'hAD);
        pulse_start(0);
        n_cmp++;
        if (wl_s[0] !== 9'd0 || in_ready_s[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL start_ignored got wl=%0d rdy=%b want 0/1",
                     wl_s[0], in_ready_s[0]);
        end
        send_byte(0, 8'hBE);
        send_byte(0, 8'hEF);
        wait_done(0);
        n_cmp++;
        if (wl_s[0] !== 9'd1 || cpu_hold_s[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL reload_final got wl=%0d hold=%b want 1/0",
                     wl_s[0], cpu_hold_s[0]);
        end
        check_drained("reload");
    endtask

    task automatic test_base_addr;
        logic [31:0] w;
        pulse_start(1);
        send_word(1, 32'd3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            w = $urandom();
            push_exp(1, 32'h400 + 32'(4 * k), w);
            send_word(1, w, 1'b0);
        end
        wait_done(1);
        n_cmp++;
        if (wl_s[1] !== 9'd3 || err_s[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL base_final got wl=%0d err=%b want 3/0",
                     wl_s[1], err_s[1]);
        end
        check_drained("base");
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_s[i]    = 1'b0;
            in_valid_s[i] = 1'b0;
            in_data_s[i]  = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_gaps();
        test_empty();
        test_overflow();
        test_reload();
        test_base_addr();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
